// File: rtl/store_buffer_ctrl.sv
// In-order store queue drained to data memory over req/gnt, with youngest-match
// store-to-load forwarding and a stall when a load only partially overlaps queued bytes.
module store_buffer_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_strb,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W/8-1:0] ld_strb,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic                ld_stall,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                fence_req,
  output logic                fence_done,
  output logic                sb_empty,
  output logic                dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WA_W   = ADDR_W - 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_t;

  logic [WA_W-1:0]   ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [STRB_W-1:0] ent_strb [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  drain_state_t      state;
  drain_state_t      state_next;
  logic              fence_active;
  logic              fence_fire;
  logic              push;
  logic              pop;
  logic              full;

  logic              match_found;
  logic              any_overlap;
  logic              full_cover;
  logic [PTR_W-1:0]  lk_idx;
  logic [DATA_W-1:0] y_data;
  logic [STRB_W-1:0] y_strb;
  logic [DATA_W-1:0] byte_mask;

  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Handshakes: a store transfers on a rising edge with st_valid && st_ready, a drain
  // write on a rising edge with mem_req && mem_gnt; mem_req and the head fields hold until gnt.
  assign full     = (count == CNT_W'(DEPTH));
  assign sb_empty = (count == '0);
  assign st_ready = !full && !fence_active;
  assign push     = st_valid && st_ready;
  assign pop      = (state == S_REQ) && mem_gnt;

  assign mem_addr  = {ent_addr[head], 2'b00};
  assign mem_wdata = ent_data[head];
  assign mem_wstrb = ent_strb[head];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_strb[i] <= '0;
      end
    end else if (push) begin
      ent_addr[tail] <= st_addr[ADDR_W-1:2];
      ent_data[tail] <= st_data;
      ent_strb[tail] <= st_strb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // A push into an empty queue raises mem_req on the very next cycle.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0 || push) state_next = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt && count <= CNT_W'(1) && !push) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Fence completes one cycle after a cycle that saw the queue empty with nothing arriving.
  assign fence_fire = (fence_active || fence_req) && (count == '0) && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fence_active <= 1'b0;
      fence_done   <= 1'b0;
    end else begin
      fence_done <= fence_fire;
      if (fence_fire)     fence_active <= 1'b0;
      else if (fence_req) fence_active <= 1'b1;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    match_found = 1'b0;
    any_overlap = 1'b0;
    lk_idx      = '0;
    y_data      = '0;
    y_strb      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head + PTR_W'(k);
      if (CNT_W'(k) < count && ent_addr[lk_idx] == ld_addr[ADDR_W-1:2]) begin
        match_found = 1'b1;
        y_data      = ent_data[lk_idx];
        y_strb      = ent_strb[lk_idx];
        if ((ent_strb[lk_idx] & ld_strb) != '0) any_overlap = 1'b1;
      end
    end
  end

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[8*b +: 8] = {8{ld_strb[b]}};
    end
  end

  assign full_cover = match_found && ((y_strb & ld_strb) == ld_strb);
  assign ld_hit     = ld_valid && full_cover;
  assign ld_stall   = ld_valid && !full_cover && any_overlap;
  assign ld_data    = ld_hit ? (y_data & byte_mask) : '0;

endmodule
